fetch_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 58 +++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data width, fetch FSM encoding and the
// default reset PC, exception vector and bubble instruction.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0040_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT   = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned, so the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register holding an instruction, its PC+4 and a valid
// bit. Squash wins over hold; with neither asserted the inputs are loaded.
// When squashed, the PC+4 field keeps its old value because it has no
// meaning while valid is low.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            squash,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc_plus4,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    // Choose between squashing to a bubble, holding, or loading a new entry.
    always_comb begin
        inst_d     = inst_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (squash) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!hold) begin
            inst_d     = in_inst;
            pc_plus4_d = in_pc_plus4;
            valid_d    = in_valid;
        end
    end

    // Register storage; reset leaves a bubble in the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q     <= NOP_INST;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign inst     = inst_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, boot/exception
// FSM, EPC capture and the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds fetch and stall counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            exception,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic            if_id_valid,
    output logic [XLEN-1:0] epc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] fetch_cnt,
    output logic [XLEN-1:0] stall_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_hold;
    logic            ifid_squash;
    logic            take_exc;
    logic            unused_redirect_lsbs;

    assign pc_plus4             = pc_q + 32'd4;
    assign take_exc             = exception && if_id_valid;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state, next-PC and IF/ID control, following the RUN priority order.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        ifid_hold   = 1'b0;
        ifid_squash = 1'b0;
        case (state_q)
            BOOT: begin
                state_d   = RUN;
                ifid_hold = 1'b1;
            end
            EXC: begin
                state_d = RUN;
                pc_d    = pc_plus4;
            end
            RUN: begin
                if (take_exc) begin
                    pc_d        = EXC_VECTOR;
                    epc_d       = if_id_pc_plus4 - 32'd4;
                    ifid_squash = 1'b1;
                    state_d     = EXC;
                end else if (redirect_valid) begin
                    pc_d        = word_align(redirect_pc);
                    ifid_squash = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (flush) begin
                    pc_d        = pc_plus4;
                    ifid_squash = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            default: begin
                state_d   = RUN;
                ifid_hold = 1'b1;
            end
        endcase
    end

    // PC, EPC and FSM state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .hold       (ifid_hold),
        .squash     (ifid_squash),
        .in_valid   (1'b1),
        .in_inst    (imem_rdata),
        .in_pc_plus4(pc_plus4),
        .inst       (if_id_inst),
        .pc_plus4   (if_id_pc_plus4),
        .valid      (if_id_valid)
    );

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign epc       = epc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_win;
    logic            fetch_load;

    assign stall_win  = (state_q == RUN) && !take_exc && !redirect_valid && stall;
    assign fetch_load = !ifid_hold && !ifid_squash;

    // Counter increments for valid IF/ID loads and winning stall cycles.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_load) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (stall_win)  stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Expected outputs come from a small
// behavioural model of the fetch stage and are queued as each cycle's
// stimulus is applied, then popped and compared after the clock edge.
module tb_fetch_stage;

    localparam logic [31:0] T_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] T_EXC_VEC  = 32'h8000_0180;
    localparam logic [31:0] T_NOP      = 32'h0000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXC  = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] epc;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, redirect_valid, exception;
    logic [31:0] redirect_pc;
    logic [31:0] imem_rdata, imem_addr, pc, if_id_inst, if_id_pc_plus4, epc;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    int          m_state;
    logic [31:0] m_pc, m_inst, m_pcp4, m_epc, m_fetch, m_stall;
    logic        m_valid;

    always #5 clk = ~clk;

    // Instruction memory: a distinct word for every address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h2008_0005 + (a - 32'h0040_0000);
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exception     (exception),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .if_id_inst    (if_id_inst),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .epc           (epc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic modelReset();
        m_state = M_BOOT;
        m_pc    = T_RESET_PC;
        m_inst  = T_NOP;
        m_pcp4  = 32'h0;
        m_valid = 1'b0;
        m_epc   = 32'h0;
        m_fetch = 32'h0;
        m_stall = 32'h0;
    endtask

    // Reset values must be visible without any clock edge.
    task automatic checkReset();
        checkOutput("rst_pc", pc, T_RESET_PC);
        checkOutput("rst_addr", imem_addr, T_RESET_PC);
        checkOutput("rst_inst", if_id_inst, T_NOP);
        checkOutput("rst_pcp4", if_id_pc_plus4, 32'h0);
        checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_fcnt", fetch_cnt, 32'h0);
        checkOutput("rst_scnt", stall_cnt, 32'h0);
`endif
    endtask

    // Behavioural model of one clock of the fetch stage.
    task automatic modelStep(input logic st, input logic fl, input logic rv,
                             input logic [31:0] rpc, input logic ex);
        if (m_state == M_BOOT) begin
            m_state = M_RUN;
        end else if (m_state == M_EXC) begin
            m_inst  = imem_word(m_pc);
            m_pcp4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fetch = m_fetch + 32'd1;
            m_state = M_RUN;
        end else if (ex && m_valid) begin
            m_epc   = m_pcp4 - 32'd4;
            m_pc    = T_EXC_VEC;
            m_inst  = T_NOP;
            m_valid = 1'b0;
            m_state = M_EXC;
        end else if (rv) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_inst  = T_NOP;
            m_valid = 1'b0;
        end else if (st) begin
            m_stall = m_stall + 32'd1;
        end else if (fl) begin
            m_pc    = m_pc + 32'd4;
            m_inst  = T_NOP;
            m_valid = 1'b0;
        end else begin
            m_inst  = imem_word(m_pc);
            m_pcp4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fetch = m_fetch + 32'd1;
        end
    endtask

    // Drive one cycle of inputs (caller is at a falling edge), queue the
    // expected result, then compare just after the rising edge.
    task automatic applyStimulus(input logic st, input logic fl, input logic rv,
                                 input logic [31:0] rpc, input logic ex);
        exp_t e;
        stall          = st;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exception      = ex;
        modelStep(st, fl, rv, rpc, ex);
        sb.push_back('{m_pc, m_inst, m_pcp4, m_valid, m_epc, m_fetch, m_stall});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            checkOutput("pc", pc, e.pc);
            checkOutput("imem_addr", imem_addr, e.pc);
            checkOutput("inst", if_id_inst, e.inst);
            checkOutput("valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            if (e.valid) checkOutput("pcp4", if_id_pc_plus4, e.pcp4);
            checkOutput("epc", epc, e.epc);
`ifdef FETCH_PERF_CNT_EN
            checkOutput("fetch_cnt", fetch_cnt, e.fcnt);
            checkOutput("stall_cnt", stall_cnt, e.scnt);
`endif
        end
        @(negedge clk);
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exception      = 1'b0;
        modelReset();
        #2;
        checkReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Boot cycle: PC holds, IF/ID stays empty.
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("boot_pc", pc, 32'h0040_0000);
        checkOutput("boot_valid", {31'b0, if_id_valid}, 32'h0);

        // First fetch from the reset PC, then three more sequential words.
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("first_pcp4", if_id_pc_plus4, 32'h0040_0004);
        checkOutput("first_inst", if_id_inst, 32'h2008_0005);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("seq_pc", pc, 32'h0040_0010);

        // Two stall cycles, then stall together with flush.
        applyStimulus(1, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0);
        applyStimulus(1, 1, 0, 32'h0, 0);
        checkOutput("stall_pc", pc, 32'h0040_0010);
        checkOutput("stallflush_valid", {31'b0, if_id_valid}, 32'h1);

        // Redirect overriding a stall, with unaligned target bits.
        applyStimulus(1, 0, 1, 32'h0040_0103, 0);
        checkOutput("redir_pc", pc, 32'h0040_0100);
        checkOutput("redir_valid", {31'b0, if_id_valid}, 32'h0);

        // Fetch the word at 0x0040_0020 then take an exception on it.
        applyStimulus(0, 0, 1, 32'h0040_0020, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 1);
        checkOutput("exc_epc", epc, 32'h0040_0020);
        checkOutput("exc_pc", pc, 32'h8000_0180);
        applyStimulus(1, 1, 1, 32'h0000_1000, 1);
        checkOutput("exc_exit_pc", pc, 32'h8000_0184);
        checkOutput("exc_exit_epc", epc, 32'h0040_0020);

        // Exception against an empty IF/ID is ignored.
        applyStimulus(0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("bubble_exc_pc", pc, 32'h8000_018C);
        checkOutput("bubble_exc_epc", epc, 32'h0040_0020);

        // PC wraps from the top of the address space.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("wrap_pc", pc, 32'h0000_0000);

        // Mixed random traffic.
        for (int i = 0; i < 150; i++) begin
            applyStimulus(($urandom % 5) == 0, ($urandom % 7) == 0, ($urandom % 9) == 0,
                          $urandom, ($urandom % 6) == 0);
        end

        // Asynchronous reset mid-stream, then a fresh boot.
        reset = 1'b1;
        #1;
        checkReset();
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("reboot_pcp4", if_id_pc_plus4, 32'h0040_0004);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
